lead_one_normalizer: RTL and testbench

- Parametrised, pipelined leading-one detector and normaliser for the floating-point adder datapath.
- Takes the raw post-add mantissa and exponent, finds the most-significant set bit, and left-shifts the mantissa so that bit lands in the MSB.
- Decrements the exponent by the shift amount, clamping to a denormal when the exponent would go negative.
- Sits between the mantissa adder and the rounding stage, with valid/ready handshakes on both sides.

---
 rtl/lead_one_normalizer.sv | 217 +++++++++++++++++++++
 tb/tb_lead_one_normalizer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lead_one_normalizer.sv
// -----------------------------------------------------------------------------
// lead_one_normalizer
//
// Two-stage pipelined leading-one detector and normaliser for the
// floating-point adder datapath. It sits between the mantissa adder and the
// rounding stage.
//   Stage 1 finds the most-significant set bit of the raw mantissa and
//           registers the word together with its index and shift amount.
//   Stage 2 left-shifts the mantissa so the leading one lands in the MSB and
//           lowers the exponent by the same amount. If the exponent would go
//           negative, the shift is limited to the exponent and the result is
//           flagged as denormal.
// Both sides use valid/ready handshakes. The pipeline holds up to two words
// while the downstream stalls.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   mant_in, exp_in       unnormalised mantissa and biased exponent
//   out_valid / out_ready downstream handshake
//   mant_out, exp_out     normalised mantissa and adjusted exponent
//   pos_out               index of the leading one in mant_in
//   zero_out              mant_in was all zeros
//   uflow_out             shift was clamped by the exponent (denormal result)
// -----------------------------------------------------------------------------
module lead_one_normalizer #(
  parameter  int WIDTH = 12,
  parameter  int EXP_W = 8,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mant_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mant_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [POS_W-1:0] pos_out,
  output logic             zero_out,
  output logic             uflow_out
);

  // Exponent and shift amount are compared in a common unsigned width.
  localparam int CMP_W = (EXP_W > POS_W) ? EXP_W : POS_W;

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_load;

  // Stage 2 can take a word when it is empty or when its word leaves this cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  // Stage 1 can take a word when it is empty or when it hands its word on.
  // in_valid does not feed into this term.
  assign in_ready = !s1_valid_q || s2_load;

  // ---------------------------------------------------------------------------
  // Stage 1: priority detect
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0] det_pos;
  logic [POS_W-1:0] det_shamt;
  logic             det_zero;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    det_pos  = POS_W'(WIDTH - 1);
    det_zero = 1'b1;
    // The scan runs upward, so the highest set bit is the last one written.
    for (int i = 0; i < WIDTH; i++) begin
      if (mant_in[i]) begin
        det_pos  = POS_W'(i);
        det_zero = 1'b0;
      end
    end
    det_shamt = POS_W'(WIDTH - 1) - det_pos;
  end

  logic [WIDTH-1:0] s1_mant_q,  s1_mant_d;
  logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic [POS_W-1:0] s1_pos_q,   s1_pos_d;
  logic [POS_W-1:0] s1_shamt_q, s1_shamt_d;
  logic             s1_zero_q,  s1_zero_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_pos_d   = s1_pos_q;
    s1_shamt_d = s1_shamt_q;
    s1_zero_d  = s1_zero_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      // The data registers load only for a real word. During bubbles the
      // stage keeps its last contents, which nothing downstream uses.
      if (in_valid) begin
        s1_mant_d  = mant_in;
        s1_exp_d   = exp_in;
        s1_pos_d   = det_pos;
        s1_shamt_d = det_shamt;
        s1_zero_d  = det_zero;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift and exponent adjust
  // ---------------------------------------------------------------------------
  logic [CMP_W-1:0] exp_ext;
  logic [CMP_W-1:0] shamt_ext;
  logic [CMP_W-1:0] exp_diff;
  logic [WIDTH-1:0] norm_mant;
  logic [EXP_W-1:0] norm_exp;
  logic             norm_uflow;

  assign exp_ext   = CMP_W'(s1_exp_q);
  assign shamt_ext = CMP_W'(s1_shamt_q);
  assign exp_diff  = exp_ext - shamt_ext;

  always_comb begin
    norm_mant  = '0;
    norm_exp   = '0;
    norm_uflow = 1'b0;
    if (s1_zero_q) begin
      norm_mant  = '0;
      norm_exp   = '0;
      norm_uflow = 1'b0;
    end else if (exp_ext >= shamt_ext) begin
      norm_mant  = s1_mant_q << s1_shamt_q;
      norm_exp   = EXP_W'(exp_diff);
    end else begin
      // The exponent runs out before the leading one reaches the MSB.
      // Shift only as far as the exponent allows and mark the result denormal.
      // The exponent is below shamt here, so this shift drops no set bits.
      norm_mant  = s1_mant_q << s1_exp_q;
      norm_exp   = '0;
      norm_uflow = 1'b1;
    end
  end

  logic [WIDTH-1:0] mant_out_q,  mant_out_d;
  logic [EXP_W-1:0] exp_out_q,   exp_out_d;
  logic [POS_W-1:0] pos_out_q,   pos_out_d;
  logic             zero_out_q,  zero_out_d;
  logic             uflow_out_q, uflow_out_d;

  always_comb begin
    s2_valid_d  = s2_valid_q;
    mant_out_d  = mant_out_q;
    exp_out_d   = exp_out_q;
    pos_out_d   = pos_out_q;
    zero_out_d  = zero_out_q;
    uflow_out_d = uflow_out_q;
    // The output registers change only when stage 2 loads. While the
    // downstream stalls, every output therefore holds its value.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        mant_out_d  = norm_mant;
        exp_out_d   = norm_exp;
        pos_out_d   = s1_pos_q;
        zero_out_d  = s1_zero_q;
        uflow_out_d = norm_uflow;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments give every flop the value from before the
  // edge, so the two stages shift in lockstep regardless of process order.
  // The data registers are reset along with the valid flags, so all outputs
  // read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_pos_q    <= '0;
      s1_shamt_q  <= '0;
      s1_zero_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      mant_out_q  <= '0;
      exp_out_q   <= '0;
      pos_out_q   <= '0;
      zero_out_q  <= 1'b0;
      uflow_out_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mant_q   <= s1_mant_d;
      s1_exp_q    <= s1_exp_d;
      s1_pos_q    <= s1_pos_d;
      s1_shamt_q  <= s1_shamt_d;
      s1_zero_q   <= s1_zero_d;
      s2_valid_q  <= s2_valid_d;
      mant_out_q  <= mant_out_d;
      exp_out_q   <= exp_out_d;
      pos_out_q   <= pos_out_d;
      zero_out_q  <= zero_out_d;
      uflow_out_q <= uflow_out_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign mant_out  = mant_out_q;
  assign exp_out   = exp_out_q;
  assign pos_out   = pos_out_q;
  assign zero_out  = zero_out_q;
  assign uflow_out = uflow_out_q;

endmodule

// File: tb/tb_lead_one_normalizer.sv
// -----------------------------------------------------------------------------
// tb_lead_one_normalizer
//
// Directed bench for lead_one_normalizer with WIDTH=12 and EXP_W=8. Inputs
// change 1 ns after a rising edge. Outputs are sampled at that same point,
// well away from the next edge. Every expected value is worked out by hand
// from the normalisation rules.
// -----------------------------------------------------------------------------
module tb_lead_one_normalizer;

  localparam int WIDTH = 12;
  localparam int EXP_W = 8;
  localparam int POS_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mant_in;
  logic [EXP_W-1:0] exp_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] mant_out;
  logic [EXP_W-1:0] exp_out;
  logic [POS_W-1:0] pos_out;
  logic             zero_out;
  logic             uflow_out;

  int checks = 0;
  int errors = 0;

  lead_one_normalizer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .pos_out   (pos_out),
    .zero_out  (zero_out),
    .uflow_out (uflow_out)
  );

  always #5 clk = ~clk;

  // Guards against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic vld,
                           input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e,
                           input logic [POS_W-1:0] p, input logic z,
                           input logic u);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
    check({tag, ".mant_out"},  32'(mant_out),  32'(m));
    check({tag, ".exp_out"},   32'(exp_out),   32'(e));
    check({tag, ".pos_out"},   32'(pos_out),   32'(p));
    check({tag, ".zero_out"},  32'(zero_out),  32'(z));
    check({tag, ".uflow_out"}, 32'(uflow_out), 32'(u));
  endtask

  // Advances to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a single cycle and follows it through the
  // pipeline. While in_valid is low, the inputs carry garbage that the
  // block must ignore.
  task automatic send_and_check(input string tag,
                                input logic [WIDTH-1:0] m_in,
                                input logic [EXP_W-1:0] e_in,
                                input logic [WIDTH-1:0] m,
                                input logic [EXP_W-1:0] e,
                                input logic [POS_W-1:0] p,
                                input logic z, input logic u);
    in_valid = 1'b1;
    mant_in  = m_in;
    exp_in   = e_in;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    mant_in  = 12'hfff;
    exp_in   = 8'hff;
    check({tag, ".latency_mid"}, 32'(out_valid), 32'd0);
    tick();
    check_out(tag, 1'b1, m, e, p, z, u);
    tick();
    check({tag, ".bubble"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mant_in   = '0;
    exp_in    = '0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    check_out("reset", 1'b0, 12'h000, 8'd0, 4'd0, 1'b0, 1'b0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset.in_ready", 32'(in_ready), 32'd1);
    check("post_reset.out_valid", 32'(out_valid), 32'd0);

    // Directed normalisation vectors.
    send_and_check("low_bit",  12'h001, 8'd20, 12'h800, 8'd9, 4'd0,  1'b0, 1'b0);
    send_and_check("normal",   12'h800, 8'd5,  12'h800, 8'd5, 4'd11, 1'b0, 1'b0);
    send_and_check("boundary", 12'h010, 8'd7,  12'h800, 8'd0, 4'd4,  1'b0, 1'b0);
    send_and_check("clamp",    12'h010, 8'd3,  12'h080, 8'd0, 4'd4,  1'b0, 1'b1);
    send_and_check("zero",     12'h000, 8'd7,  12'h000, 8'd0, 4'd11, 1'b1, 1'b0);
    send_and_check("mixed",    12'h35a, 8'd1,  12'h6b4, 8'd0, 4'd9,  1'b0, 1'b1);

    // Back-to-back words at full throughput.
    in_valid = 1'b1; mant_in = 12'h100; exp_in = 8'd10;  // shamt 3
    tick();
    in_valid = 1'b1; mant_in = 12'h040; exp_in = 8'd2;   // shamt 5, clamp
    tick();
    in_valid = 1'b0; mant_in = 12'hfff;
    check_out("b2b_0", 1'b1, 12'h800, 8'd7, 4'd8, 1'b0, 1'b0);
    tick();
    check_out("b2b_1", 1'b1, 12'h100, 8'd0, 4'd6, 1'b0, 1'b1);
    tick();
    check("b2b.drain", 32'(out_valid), 32'd0);

    // Backpressure. A, B and C are all sent with exponent 20.
    out_ready = 1'b0;
    in_valid = 1'b1; mant_in = 12'h001; exp_in = 8'd20;  // A
    check("bp.A_ready", 32'(in_ready), 32'd1);
    tick();
    mant_in = 12'h002;                                   // B
    check("bp.B_ready", 32'(in_ready), 32'd1);
    tick();
    mant_in = 12'h004;                                   // C
    check("bp.C_blocked", 32'(in_ready), 32'd0);
    check_out("bp.hold_A0", 1'b1, 12'h800, 8'd9, 4'd0, 1'b0, 1'b0);
    tick();
    check("bp.C_still_blocked", 32'(in_ready), 32'd0);
    check_out("bp.hold_A1", 1'b1, 12'h800, 8'd9, 4'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp.ready_on_release", 32'(in_ready), 32'd1);
    tick();                       // A leaves, B to stage 2, C accepted
    in_valid = 1'b0; mant_in = 12'hfff;
    check_out("bp.B", 1'b1, 12'h800, 8'd10, 4'd1, 1'b0, 1'b0);
    tick();
    check_out("bp.C", 1'b1, 12'h800, 8'd11, 4'd2, 1'b0, 1'b0);
    tick();
    check("bp.no_dup", 32'(out_valid), 32'd0);

    // Reset mid-stream with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; mant_in = 12'h008; exp_in = 8'd30;
    tick();
    mant_in = 12'h020;
    tick();
    in_valid = 1'b0;
    check("rst_mid.full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_out("rst_mid.async", 1'b0, 12'h000, 8'd0, 4'd0, 1'b0, 1'b0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst_mid.first_ready", 32'(in_ready), 32'd1);
    check("rst_mid.no_stale0", 32'(out_valid), 32'd0);
    tick();
    check("rst_mid.no_stale1", 32'(out_valid), 32'd0);
    tick();
    check("rst_mid.no_stale2", 32'(out_valid), 32'd0);

    // The pipeline still works after the mid-stream reset.
    send_and_check("after_rst", 12'h0c0, 8'd40, 12'hc00, 8'd36, 4'd7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
